// File: rtl/fifo_wptr_full_pkg.sv
// Shared definitions for the async FIFO pointer logic: depth helper and
// Gray/binary conversions. The read-side controller imports the same package.
package fifo_wptr_full_pkg;

    // Widest pointer the helpers handle; callers zero-extend and truncate.
    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Storage depth for a given address width.
    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Binary to Gray. Zero-extended upper bits stay zero, so the result is
    // valid for any pointer width up to PTR_MAX_W.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it. Zero-extended upper bits contribute nothing.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_full_sync_r2w.sv
// Multi-flop synchronizer for a Gray pointer crossing into another clock
// domain. Nothing but flops sits between d and q.
module sync_r2w #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    // Shift the incoming pointer through the flop chain; stage 0 samples d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side controller of the async FIFO: binary/Gray write pointers,
// storage write port, synchronized read pointer and registered full,
// almost-full, level and sticky overflow flags.
module fifo_wptr_full
    import fifo_wptr_full_pkg::*;
#(
    parameter int ADDR_SIZE          = 5,
    parameter int ALMOST_FULL_MARGIN = 4,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 winc,
    input  logic [ADDR_SIZE:0]   rptr,
    input  logic                 woverflow_clr,
    output logic [ADDR_SIZE-1:0] waddr,
    output logic                 wclk_en,
    output logic [ADDR_SIZE:0]   wptr,
    output logic                 wfull,
    output logic                 walmost_full,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 woverflow
);

    localparam int A     = ADDR_SIZE;
    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - ALMOST_FULL_MARGIN);

    // Elaboration-time guards on the parameter ranges the logic relies on.
    generate
        if (ADDR_SIZE < 2 || ADDR_SIZE >= PTR_MAX_W) begin : g_bad_addr
            $error("fifo_wptr_full: ADDR_SIZE out of range");
        end
        if (ALMOST_FULL_MARGIN < 1 || ALMOST_FULL_MARGIN > DEPTH - 1) begin : g_bad_margin
            $error("fifo_wptr_full: ALMOST_FULL_MARGIN must be 1..DEPTH-1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("fifo_wptr_full: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] wq_rptr;
    logic [PW-1:0] rqbin;
    logic [PW-1:0] level_next;
    logic          full_next;
    logic          almost_next;
    logic          overflow_next;

    // Read pointer enters this domain only through the synchronizer.
    sync_r2w #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rptr),
        .q     (wq_rptr)
    );

    // Storage write port. The reset term keeps the array from being written
    // while the controller is held in reset, even if winc is high.
    assign wclk_en = winc & ~wfull & wrst_n;
    assign waddr   = wbin[A-1:0];

    // Next pointer, occupancy and flag terms. Level uses the synchronized
    // (stale) read pointer, so it can only over-report occupancy; full and
    // almost-full therefore release late but never early.
    always_comb begin
        wbinnext      = wbin + PW'(wclk_en);
        wgraynext     = PW'(bin2gray(ptr_word_t'(wbinnext)));
        rqbin         = PW'(gray2bin(ptr_word_t'(wq_rptr)));
        level_next    = wbinnext - rqbin;
        full_next     = (wgraynext == {~wq_rptr[A:A-1], wq_rptr[A-2:0]});
        almost_next   = (level_next >= AF_THRESH);
        // Set dominates a simultaneous clear so no overflow event is lost.
        overflow_next = (winc & wfull) | (woverflow & ~woverflow_clr);
    end

    // Pointer registers. wptr is a bare flop output for a glitch-free crossing.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin <= '0;
            wptr <= '0;
        end else begin
            wbin <= wbinnext;
            wptr <= wgraynext;
        end
    end

    // Registered status flags, updated on the same edge as the write.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wfull        <= full_next;
            walmost_full <= almost_next;
            wlevel       <= level_next;
            woverflow    <= overflow_next;
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full. The reference model tracks the
// write count and a delayed copy of the read count and derives every flag
// from plain occupancy arithmetic.
module tb_fifo_wptr_full;

    localparam int A     = 5;
    localparam int PW    = A + 1;
    localparam int DEPTH = 32;
    localparam int MARG  = 4;
    localparam int SYNC  = 2;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic          woverflow_clr = 1'b0;
    logic [PW-1:0] rptr;
    logic [A-1:0]  waddr;
    logic          wclk_en;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          walmost_full;
    logic [PW-1:0] wlevel;
    logic          woverflow;

    int rbin = 0;
    logic [PW-1:0] rb6;
    assign rb6  = PW'(rbin);
    assign rptr = rb6 ^ (rb6 >> 1);

    int tests_run = 0;
    int failed    = 0;

    // reference model state
    int m_wb, m_total, m_lvl;
    bit m_full, m_af, m_ovf;
    int rhist[$];

    fifo_wptr_full #(
        .ADDR_SIZE          (A),
        .ALMOST_FULL_MARGIN (MARG),
        .SYNC_STAGES        (SYNC)
    ) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .winc          (winc),
        .rptr          (rptr),
        .woverflow_clr (woverflow_clr),
        .waddr         (waddr),
        .wclk_en       (wclk_en),
        .wptr          (wptr),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .woverflow     (woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [PW-1:0] gray_of(input int v);
        logic [PW-1:0] b;
        b = PW'(v % 64);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wb = 0; m_total = 0; m_lvl = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
        rhist.delete();
        repeat (SYNC) rhist.push_back(0);
    endtask

    // One wclk edge; advance the model with the inputs present at the edge,
    // then settle 1ns past the edge.
    task automatic clk_edge();
        bit en, ovf;
        int rq;
        @(posedge wclk);
        en  = winc && !m_full;
        ovf = (winc && m_full) || (m_ovf && !woverflow_clr);
        m_wb    = (m_wb + (en ? 1 : 0)) % 64;
        m_total = m_total + (en ? 1 : 0);
        rq = rhist.pop_front();
        rhist.push_back(rbin % 64);
        m_lvl  = (m_wb - rq + 64) % 64;
        m_full = (m_lvl == DEPTH);
        m_af   = (m_lvl >= DEPTH - MARG);
        m_ovf  = ovf;
        #1;
    endtask

    task automatic pulse_reset();
        wrst_n = 1'b0;
        #2;
        wrst_n = 1'b1;
        winc = 1'b0; woverflow_clr = 1'b0; rbin = 0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        winc = 1'b1;
        #2;
        tests_run++;
        if ({waddr, wptr, wlevel, wfull, walmost_full, woverflow, wclk_en} !== '0) begin
            failed++;
            $display("FAIL reset_state: got waddr=%0d wptr=%0d wlevel=%0d full=%0b af=%0b ovf=%0b en=%0b expected all 0",
                     waddr, wptr, wlevel, wfull, walmost_full, woverflow, wclk_en);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        winc = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid_burst();
        winc = 1'b1;
        repeat (10) clk_edge();
        tests_run++;
        if (wlevel !== 6'd10) begin
            failed++; $display("FAIL burst_level: got %0d expected 10", wlevel);
        end
        #2;
        wrst_n = 1'b0;
        #1;
        tests_run++;
        if ({waddr, wptr, wlevel, wfull, woverflow, wclk_en} !== '0) begin
            failed++;
            $display("FAIL mid_reset: got waddr=%0d wptr=%0d wlevel=%0d full=%0b ovf=%0b en=%0b expected all 0",
                     waddr, wptr, wlevel, wfull, woverflow, wclk_en);
        end
        wrst_n = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (waddr !== 5'd0 || wclk_en !== 1'b1) begin
            failed++; $display("FAIL post_reset_addr: got waddr=%0d en=%0b expected 0/1", waddr, wclk_en);
        end
        clk_edge();
        tests_run++;
        if (wlevel !== 6'd1 || wptr !== 6'd1) begin
            failed++; $display("FAIL post_reset_write: got wlevel=%0d wptr=%0d expected 1/1", wlevel, wptr);
        end
    endtask

    task automatic test_fill();
        pulse_reset();
        winc = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            tests_run++;
            if (waddr !== 5'(i) || wclk_en !== 1'b1) begin
                failed++; $display("FAIL fill_addr: got waddr=%0d en=%0b expected %0d/1", waddr, wclk_en, i);
            end
            clk_edge();
            tests_run++;
            if (wlevel !== 6'(i + 1) || walmost_full !== (i + 1 >= 28) || wfull !== (i + 1 == 32)) begin
                failed++;
                $display("FAIL fill_flags: write %0d got level=%0d af=%0b full=%0b expected level=%0d af=%0b full=%0b",
                         i + 1, wlevel, walmost_full, wfull, i + 1, (i + 1 >= 28), (i + 1 == 32));
            end
        end
        tests_run++;
        if (wptr !== 6'b110000) begin
            failed++; $display("FAIL fill_wptr: got %b expected 110000", wptr);
        end
    endtask

    task automatic test_overflow();
        winc = 1'b1;
        repeat (3) begin
            #1;
            tests_run++;
            if (wclk_en !== 1'b0 || waddr !== 5'd0) begin
                failed++; $display("FAIL ovf_block: got en=%0b waddr=%0d expected 0/0", wclk_en, waddr);
            end
            clk_edge();
            tests_run++;
            if (woverflow !== 1'b1 || wlevel !== 6'd32 || wptr !== 6'b110000) begin
                failed++; $display("FAIL ovf_set: got ovf=%0b level=%0d wptr=%b expected 1/32/110000",
                                   woverflow, wlevel, wptr);
            end
        end
        winc = 1'b0; woverflow_clr = 1'b1;
        clk_edge();
        tests_run++;
        if (woverflow !== 1'b0) begin
            failed++; $display("FAIL ovf_clear: got %0b expected 0", woverflow);
        end
        winc = 1'b1;
        clk_edge();
        tests_run++;
        if (woverflow !== 1'b1) begin
            failed++; $display("FAIL ovf_set_wins: got %0b expected 1", woverflow);
        end
        winc = 1'b0; woverflow_clr = 1'b0;
    endtask

    task automatic test_drain();
        rbin = 1;
        for (int e = 1; e <= SYNC + 1; e++) begin
            clk_edge();
            tests_run++;
            if (wfull !== (e <= SYNC)) begin
                failed++; $display("FAIL drain_full: edge %0d got %0b expected %0b", e, wfull, (e <= SYNC));
            end
        end
        tests_run++;
        if (wlevel !== 6'd31) begin
            failed++; $display("FAIL drain_level: got %0d expected 31", wlevel);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        winc = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            rbin = (m_total >= 2) ? m_total - 2 : 0;
            clk_edge();
            tests_run++;
            if (wptr !== gray_of(n) || wfull !== 1'b0 || (n >= 8 && wlevel !== 6'd5)) begin
                failed++; $display("FAIL wrap: word %0d got wptr=%b full=%0b level=%0d expected %b/0/5",
                                   n, wptr, wfull, wlevel, gray_of(n));
            end
        end
        winc = 1'b0;
    endtask

    task automatic test_race();
        pulse_reset();
        winc = 1'b1;
        repeat (DEPTH) clk_edge();
        tests_run++;
        if (wfull !== 1'b1) begin
            failed++; $display("FAIL race_full: got %0b expected 1", wfull);
        end
        winc = 1'b0; rbin = 1;
        for (int e = 1; e <= SYNC + 1; e++) begin
            clk_edge();
            tests_run++;
            if (wfull !== (e <= SYNC) || (e == SYNC + 1 && wlevel !== 6'd31)) begin
                failed++; $display("FAIL race_release: edge %0d got full=%0b level=%0d", e, wfull, wlevel);
            end
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 1500; c++) begin
            winc          = ($urandom_range(0, 3) != 0);
            woverflow_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) != 0 && rbin < m_total) rbin++;
            #1;
            tests_run++;
            if (wclk_en !== (winc && !m_full) || waddr !== 5'(m_wb % 32)) begin
                failed++; $display("FAIL rand_comb: cycle %0d got en=%0b waddr=%0d expected %0b/%0d",
                                   c, wclk_en, waddr, (winc && !m_full), m_wb % 32);
            end
            clk_edge();
            tests_run++;
            if (wlevel !== 6'(m_lvl) || wfull !== m_full || walmost_full !== m_af ||
                woverflow !== m_ovf || wptr !== gray_of(m_wb)) begin
                failed++;
                $display("FAIL rand_regs: cycle %0d got lvl=%0d full=%0b af=%0b ovf=%0b wptr=%b expected %0d/%0b/%0b/%0b/%b",
                         c, wlevel, wfull, walmost_full, woverflow, wptr, m_lvl, m_full, m_af, m_ovf, gray_of(m_wb));
            end
        end
        winc = 1'b0; woverflow_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_burst();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_race();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
